// File: rtl/fwvip_wb_monitor_fifo.sv
// Address-filtering FIFO behind the WB monitor record stream, with stats.
// Define FWVIP_WB_MONITOR_FIFO_TIMESTAMP_EN to prepend a 32-bit push timestamp.
module fwvip_wb_monitor_fifo #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MON_WIDTH    = ADDR_WIDTH + DATA_WIDTH
                               + DATA_WIDTH / 8 + 2,
  parameter int DEPTH        = 8,
  parameter int DROP_ON_FULL = 0,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [MON_WIDTH-1:0]    mon_dat,
  input  logic                    mon_valid,
  output logic                    mon_ready,
`ifdef FWVIP_WB_MONITOR_FIFO_TIMESTAMP_EN
  output logic [MON_WIDTH+31:0]   out_dat,
`else
  output logic [MON_WIDTH-1:0]    out_dat,
`endif
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic                    flt_en,
  input  logic [ADDR_WIDTH-1:0]   flt_base,
  input  logic [ADDR_WIDTH-1:0]   flt_mask,
  input  logic                    clear,
  output logic [$clog2(DEPTH):0]  level,
  output logic [CNT_WIDTH-1:0]    cnt_wr,
  output logic [CNT_WIDTH-1:0]    cnt_rd,
  output logic [CNT_WIDTH-1:0]    cnt_err,
  output logic [CNT_WIDTH-1:0]    cnt_filt,
  output logic [CNT_WIDTH-1:0]    cnt_drop
);

  localparam int SEL_WIDTH = DATA_WIDTH / 8;
  localparam int AW        = $clog2(DEPTH);
  localparam int OUT_WIDTH = $bits(out_dat);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [OUT_WIDTH-1:0]  mem [DEPTH];
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic [OUT_WIDTH-1:0]  rec;
  logic [ADDR_WIDTH-1:0] adr;
  logic we;
  logic err;
  logic hit;
  logic full;
  logic take;
  logic pop;
  logic push;
  logic drop;
  logic filt;
  logic mem_empty;
  logic load;
  logic bypass;
  logic mem_wr;
  logic mem_rd;

`ifdef FWVIP_WB_MONITOR_FIFO_TIMESTAMP_EN
  logic [31:0] ts;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ts <= '0;
    end else if (clear) begin
      ts <= '0;
    end else begin
      ts <= ts + 32'd1;
    end
  end

  assign rec = {ts, mon_dat};
`else
  assign rec = mon_dat;
`endif

  assign adr = mon_dat[MON_WIDTH-1 -: ADDR_WIDTH];
  assign we  = mon_dat[DATA_WIDTH+SEL_WIDTH+1];
  assign err = mon_dat[0];
  assign hit = !flt_en ||
               (((adr ^ flt_base) & flt_mask) == '0);

  assign full      = (level == FULL_LVL);
  assign mon_ready = (DROP_ON_FULL != 0) ? 1'b1 : !full;

  // A beat taken during clear is swallowed without effect.
  assign take = mon_valid && mon_ready && !clear;
  assign pop  = out_valid && out_ready;
  assign push = take && hit && (!full || pop);
  assign drop = take && hit && full && !pop;
  assign filt = take && !hit;

  // The output register is the FIFO head; mem holds what queues behind it.
  assign mem_empty = (wr_ptr == rd_ptr);
  assign load      = !out_valid || pop;
  assign bypass    = push && load && mem_empty;
  assign mem_wr    = push && !bypass;
  assign mem_rd    = load && !mem_empty;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(
    input logic [CNT_WIDTH-1:0] v
  );
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  always_ff @(posedge clock) begin
    if (mem_wr) begin
      mem[wr_ptr[AW-1:0]] <= rec;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      out_valid <= 1'b0;
      out_dat   <= '0;
      cnt_wr    <= '0;
      cnt_rd    <= '0;
      cnt_err   <= '0;
      cnt_filt  <= '0;
      cnt_drop  <= '0;
    end else if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      out_valid <= 1'b0;
      out_dat   <= '0;
      cnt_wr    <= '0;
      cnt_rd    <= '0;
      cnt_err   <= '0;
      cnt_filt  <= '0;
      cnt_drop  <= '0;
    end else begin
      if (mem_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (mem_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (load) begin
        unique case (1'b1)
          mem_rd: begin
            out_dat   <= mem[rd_ptr[AW-1:0]];
            out_valid <= 1'b1;
          end
          bypass: begin
            out_dat   <= rec;
            out_valid <= 1'b1;
          end
          default: out_valid <= 1'b0;
        endcase
      end
      unique case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (push && we) begin
        cnt_wr <= sat_inc(cnt_wr);
      end
      if (push && !we) begin
        cnt_rd <= sat_inc(cnt_rd);
      end
      if (push && err) begin
        cnt_err <= sat_inc(cnt_err);
      end
      if (filt) begin
        cnt_filt <= sat_inc(cnt_filt);
      end
      if (drop) begin
        cnt_drop <= sat_inc(cnt_drop);
      end
    end
  end

endmodule

// File: doc/fwvip_wb_monitor_fifo.md
Name: fwvip_wb_monitor_fifo

Overview:
- Downstream consumer of the WB monitor core's ready/valid record stream.
- Filters each record by an address window and buffers accepted records in a FIFO.
- Re-emits buffered records on a ready/valid output for scoreboards and loggers.
- Maintains saturating statistics counters (writes, reads, errors, filtered, dropped) for testbench inspection.

Parameters:
- ADDR_WIDTH, 32, WB address width.
- DATA_WIDTH, 32, WB data width; SEL_WIDTH = DATA_WIDTH/8.
- MON_WIDTH, ADDR_WIDTH+DATA_WIDTH+SEL_WIDTH+2, record width.
- DEPTH, 8, FIFO entries; power of 2, >= 2.
- DROP_ON_FULL, 0. 0 = backpressure input when full; 1 = always ready, discard when full.
- CNT_WIDTH, 32, width of each statistics counter.

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-low reset.
- mon_dat  in  MON_WIDTH  input record.
- mon_valid  in  1  input record valid.
- mon_ready  out  1  input ready.
- out_dat  out  MON_WIDTH (+TS_WIDTH with option)  output record.
- out_valid  out  1  output valid.
- out_ready  in  1  output ready.
- flt_en  in  1  address filter enable.
- flt_base  in  ADDR_WIDTH  filter base.
- flt_mask  in  ADDR_WIDTH  filter compare mask.
- clear  in  1  synchronous clear of counters and FIFO.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- cnt_wr, cnt_rd, cnt_err, cnt_filt, cnt_drop  out  CNT_WIDTH each  statistics.

Behaviour:
- Record layout, MSB to LSB:
  - adr [MON_WIDTH-1 -: ADDR_WIDTH]
  - we [DATA_WIDTH+SEL_WIDTH+1]
  - dat [SEL_WIDTH+1 +: DATA_WIDTH]
  - sel [1 +: SEL_WIDTH]
  - err [0]
- Reset (reset=0, async): FIFO empty; level=0; out_valid=0; out_dat=0; all counters 0. mon_ready is 1 when reset deasserts.
- Input handshake: a beat transfers when mon_valid && mon_ready.
- Filter hit: flt_en=0, or (adr & flt_mask) == (flt_base & flt_mask).
  - Miss: beat is consumed (handshake completes), not stored, cnt_filt++.
- mon_ready:
  - DROP_ON_FULL=0: mon_ready = !full. It does not depend on a same-cycle pop, which keeps the path registered-only.
  - DROP_ON_FULL=1: mon_ready = 1. A hit arriving while full and with no same-cycle pop is discarded and cnt_drop++.
  - Hit while full with a same-cycle pop in drop mode: stored, no drop.
- Every stored hit: cnt_wr++ if we=1, cnt_rd++ if we=0; additionally cnt_err++ if err=1.
- Output is registered first-word-fall-through:
  - A record pushed into an empty FIFO appears with out_valid=1 on the cycle after the push edge; latency is 1 cycle.
  - out_dat holds stable while out_valid && !out_ready.
  - Pop occurs on out_valid && out_ready.
- Simultaneous push and pop: level unchanged. Pointers wrap modulo DEPTH, with an extra MSB used for full/empty detection.
- level counts stored records, including the one presented on out_dat.
- Counters saturate at all-ones and never wrap.
- clear=1: on the next edge, FIFO is emptied (out_valid=0, level=0) and all counters are zeroed. A beat handshaked in that same cycle is discarded and not counted. clear has priority over push and pop.
- Async reset mid-transfer: all state is lost immediately; no partial record is ever emitted.
- flt_* inputs are sampled in the handshake cycle; changing them affects only subsequent beats.

Optional Feature:
- Macro: FWVIP_WB_MONITOR_FIFO_TIMESTAMP_EN.
- Defined:
  - A free-running TS_WIDTH=32 cycle counter runs from 0 after reset and wraps.
  - The counter value at the push edge is stored with each record.
  - out_dat = {timestamp, record}; out_dat width = MON_WIDTH+32.
  - clear also zeroes the timestamp counter.
- Undefined: no counter exists; out_dat width = MON_WIDTH.

Test Plan:
- Reset, then 3 writes {adr=0x1000_0000, dat=0x1234_5678, sel=0xF, we=1, err=0} with flt_en=0 and out_ready=1 -> 3 records out, each 1 cycle after its push; cnt_wr=3; cnt_rd=cnt_err=0; level returns to 0.
- flt_en=1, base=0x1000_0000, mask=0xF000_0000; send adr 0x1000_0040 and 0x2000_0000 -> only 0x1000_0040 is emitted; cnt_filt=1.
- DROP_ON_FULL=0, out_ready=0, 10 hits at DEPTH=8 -> mon_ready falls after the 8th beat; level=8; once out_ready=1, all 10 records drain in order; cnt_drop=0.
- DROP_ON_FULL=1, same stimulus -> mon_ready stays 1; cnt_drop=2; exactly records 1-8 are emitted.
- Read with err=1 -> cnt_rd=1, cnt_err=1. Then pulse clear with level=3 -> next cycle level=0, out_valid=0, all counters 0.
- With FWVIP_WB_MONITOR_FIFO_TIMESTAMP_EN: push on cycles 5 and 9 after reset -> emitted timestamps are 5 and 9, and the record fields are unchanged.
